// File: rtl/regbank_write_arbiter_pkg.sv
// Shared definitions for the register-bank write arbiter:
// mux source codes, FSM state codes, requester indices and helpers.
package regbank_write_arbiter_pkg;

  localparam logic [1:0] SRC_ALU  = 2'b00;
  localparam logic [1:0] SRC_REG  = 2'b01;
  localparam logic [1:0] SRC_IMM  = 2'b10;
  localparam logic [1:0] SRC_ZERO = 2'b11;

  localparam logic [1:0] REQ_ALU = 2'd0;
  localparam logic [1:0] REQ_REG = 2'd1;
  localparam logic [1:0] REQ_IMM = 2'd2;
  localparam logic [1:0] REQ_CLR = 2'd3;

  localparam int NREQ = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRITE  = 2'd1,
    ST_HALTED = 2'd2
  } state_e;

  typedef struct packed {
    logic [1:0] src;
    logic [2:0] dst;
  } wsel_t;

  // One-hot grant to requester index.
  function automatic logic [1:0] oh2idx(
    input logic [3:0] oh
  );
    return {oh[3] | oh[2], oh[3] | oh[1]};
  endfunction

  // Requester index to bank source-mux code.
  function automatic logic [1:0] src_of(
    input logic [1:0] idx
  );
    logic [1:0] s;
    unique case (idx)
      REQ_ALU: s = SRC_ALU;
      REQ_REG: s = SRC_REG;
      REQ_IMM: s = SRC_IMM;
      REQ_CLR: s = SRC_ZERO;
      default: s = SRC_ZERO;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way combinational arbiter: rotating priority from ptr_i when
// rr_en_i=1, else fixed priority with index 0 highest. One-hot gnt_o.
module rr_arbiter4 (
  input  logic [3:0] req_i,
  input  logic [1:0] ptr_i,
  input  logic       rr_en_i,
  output logic [3:0] gnt_o
);

  logic [1:0] base;
  logic [1:0] idx;
  logic       found;

  assign base = rr_en_i ? ptr_i : 2'd0;

  // Scan four slots starting at base; 2-bit index wraps naturally.
  always_comb begin
    gnt_o = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req_i[idx]) begin
        gnt_o[idx] = 1'b1;
        found      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regbank_write_arbiter.sv
// Shares the 8x8 register bank write port among ALU, move, immediate and
// clear requesters. Registers grant, mux/dest selects, E, Acks, WrCount.
//  in : CLK, Reset(async low), Halt, Req{A,R,I,Z}, Dst{A,R,I,Z}[2:0]
//  out: Ack{A,R,I,Z}, MS1/MS0, RS2..RS0, E, Busy, WrCount[CNT_W-1:0]
module regbank_write_arbiter
  import regbank_write_arbiter_pkg::*;
#(
  parameter bit RR_EN = 1'b1,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             Halt,
  input  logic             ReqA,
  input  logic [2:0]       DstA,
  input  logic             ReqR,
  input  logic [2:0]       DstR,
  input  logic             ReqI,
  input  logic [2:0]       DstI,
  input  logic             ReqZ,
  input  logic [2:0]       DstZ,
  output logic             AckA,
  output logic             AckR,
  output logic             AckI,
  output logic             AckZ,
  output logic             MS1,
  output logic             MS0,
  output logic             RS2,
  output logic             RS1,
  output logic             RS0,
  output logic             E,
  output logic             Busy,
  output logic [CNT_W-1:0] WrCount
);

  state_e state_q, state_d;

  logic [3:0]       req;
  logic [3:0]       gnt;
  logic [1:0]       win_idx;
  wsel_t            win;
  logic             grant_en;

  logic [1:0]       ptr_q, ptr_d;
  logic             e_q, e_d;
  logic [3:0]       ack_q, ack_d;
  wsel_t            sel_q, sel_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign req = {ReqZ, ReqI, ReqR, ReqA};

  rr_arbiter4 u_arb (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .rr_en_i (RR_EN),
    .gnt_o   (gnt)
  );

  assign win_idx = oh2idx(gnt);

  always_comb begin
    win.src = src_of(win_idx);
    unique case (1'b1)
      gnt[REQ_ALU]: win.dst = DstA;
      gnt[REQ_REG]: win.dst = DstR;
      gnt[REQ_IMM]: win.dst = DstI;
      gnt[REQ_CLR]: win.dst = DstZ;
      default:      win.dst = '0;
    endcase
  end

  // A grant is made on every edge that enters or stays in WRITE.
  always_comb begin
    state_d  = state_q;
    grant_en = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_WRITE: begin
        if (Halt) begin
          state_d = ST_HALTED;
        end else if (|req) begin
          state_d  = ST_WRITE;
          grant_en = 1'b1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_HALTED: begin
        if (!Halt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Selects hold their last value while E=0.
  always_comb begin
    e_d   = grant_en;
    ack_d = '0;
    sel_d = sel_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    if (grant_en) begin
      ack_d = gnt;
      sel_d = win;
      ptr_d = win_idx + 2'd1;
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
      ptr_q   <= REQ_ALU;
      e_q     <= 1'b0;
      ack_q   <= '0;
      sel_q   <= '{src: SRC_ZERO, dst: 3'd0};
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      e_q     <= e_d;
      ack_q   <= ack_d;
      sel_q   <= sel_d;
      cnt_q   <= cnt_d;
    end
  end

  assign AckA = ack_q[REQ_ALU];
  assign AckR = ack_q[REQ_REG];
  assign AckI = ack_q[REQ_IMM];
  assign AckZ = ack_q[REQ_CLR];

  assign {MS1, MS0}      = sel_q.src;
  assign {RS2, RS1, RS0} = sel_q.dst;

  assign E       = e_q;
  assign Busy    = e_q | (|req);
  assign WrCount = cnt_q;

endmodule

// File: tb/tb_regbank_write_arbiter.sv
// Directed bench for regbank_write_arbiter: one round-robin instance
// and one fixed-priority instance with a 2-bit write counter.
module tb_regbank_write_arbiter;

  localparam logic [3:0] KA = 4'b1000;
  localparam logic [3:0] KR = 4'b0100;
  localparam logic [3:0] KI = 4'b0010;
  localparam logic [3:0] KZ = 4'b0001;
  localparam logic [3:0] K0 = 4'b0000;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic rst_n;

  logic       h0, h1;
  logic [3:0] r0, r1;
  logic [2:0] dA0, dR0, dI0, dZ0;
  logic [2:0] dA1, dR1, dI1, dZ1;

  logic aA0, aR0, aI0, aZ0, m1_0, m0_0, s2_0, s1_0, s0_0, e0, b0;
  logic aA1, aR1, aI1, aZ1, m1_1, m0_1, s2_1, s1_1, s0_1, e1, b1;
  logic [7:0] c0;
  logic [1:0] c1;

  regbank_write_arbiter #(.RR_EN(1'b1), .CNT_W(8)) u_rr (
    .CLK(CLK), .Reset(rst_n), .Halt(h0),
    .ReqA(r0[3]), .DstA(dA0), .ReqR(r0[2]), .DstR(dR0),
    .ReqI(r0[1]), .DstI(dI0), .ReqZ(r0[0]), .DstZ(dZ0),
    .AckA(aA0), .AckR(aR0), .AckI(aI0), .AckZ(aZ0),
    .MS1(m1_0), .MS0(m0_0), .RS2(s2_0), .RS1(s1_0), .RS0(s0_0),
    .E(e0), .Busy(b0), .WrCount(c0)
  );

  regbank_write_arbiter #(.RR_EN(1'b0), .CNT_W(2)) u_fp (
    .CLK(CLK), .Reset(rst_n), .Halt(h1),
    .ReqA(r1[3]), .DstA(dA1), .ReqR(r1[2]), .DstR(dR1),
    .ReqI(r1[1]), .DstI(dI1), .ReqZ(r1[0]), .DstZ(dZ1),
    .AckA(aA1), .AckR(aR1), .AckI(aI1), .AckZ(aZ1),
    .MS1(m1_1), .MS0(m0_1), .RS2(s2_1), .RS1(s1_1), .RS0(s0_1),
    .E(e1), .Busy(b1), .WrCount(c1)
  );

  logic [18:0] obs0, obs1;
  assign obs0 = {b0, e0, aA0, aR0, aI0, aZ0,
                 m1_0, m0_0, s2_0, s1_0, s0_0, c0};
  assign obs1 = {b1, e1, aA1, aR1, aI1, aZ1,
                 m1_1, m0_1, s2_1, s1_1, s0_1, 6'b0, c1};

  typedef struct {
    string       tag;
    bit          inst;
    logic [18:0] v;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  task automatic push(input string tag, input bit inst,
                      input bit busy, input bit e,
                      input logic [3:0] ack, input logic [1:0] ms,
                      input logic [2:0] rs, input logic [7:0] cnt);
    exp_t x;
    x.tag  = tag;
    x.inst = inst;
    x.v    = {busy, e, ack, ms, rs, cnt};
    sbq.push_back(x);
  endtask

  task automatic check();
    exp_t        x;
    logic [18:0] obs;
    total++;
    if (sbq.size() == 0) begin
      bad++;
      $display("FAIL sb_empty: no expected entry");
    end else begin
      x   = sbq.pop_front();
      obs = x.inst ? obs1 : obs0;
      assert (obs === x.v) else begin
        bad++;
        $error("FAIL %s: {busy,e,ack,ms,rs,cnt} got=%b want=%b",
               x.tag, obs, x.v);
      end
    end
  endtask

  task automatic cyc();
    @(posedge CLK);
    #1;
    check();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    h0 = 1'b0; h1 = 1'b0;
    r0 = K0;   r1 = K0;
    dA0 = 3'd0; dR0 = 3'd0; dI0 = 3'd0; dZ0 = 3'd0;
    dA1 = 3'd0; dR1 = 3'd0; dI1 = 3'd0; dZ1 = 3'd0;

    @(posedge CLK);
    #1;
    push("reset", 0, 0, 0, K0, 2'b11, 3'd0, 8'd0);
    check();
    #2 rst_n = 1'b1;
    push("idle", 0, 0, 0, K0, 2'b11, 3'd0, 8'd0);
    cyc();

    // All four held: rotate A,R,I,Z,A
    dA0 = 3'd0; dR0 = 3'd1; dI0 = 3'd2; dZ0 = 3'd3;
    r0 = 4'b1111;
    push("rr_a",  0, 1, 1, KA, 2'b00, 3'd0, 8'd1); cyc();
    push("rr_r",  0, 1, 1, KR, 2'b01, 3'd1, 8'd2); cyc();
    push("rr_i",  0, 1, 1, KI, 2'b10, 3'd2, 8'd3); cyc();
    push("rr_z",  0, 1, 1, KZ, 2'b11, 3'd3, 8'd4); cyc();
    push("rr_a2", 0, 1, 1, KA, 2'b00, 3'd0, 8'd5); cyc();
    r0 = K0;
    push("rr_hold", 0, 0, 0, K0, 2'b00, 3'd0, 8'd5); cyc();

    // Single immediate load to R5
    dI0 = 3'd5;
    r0 = KI;
    push("imm5", 0, 1, 1, KI, 2'b10, 3'd5, 8'd6); cyc();
    r0 = K0;
    push("imm_hold", 0, 0, 0, K0, 2'b10, 3'd5, 8'd6); cyc();

    // Pointer after I: A and R alternate
    r0 = KA | KR;
    push("ar_a",  0, 1, 1, KA, 2'b00, 3'd0, 8'd7); cyc();
    push("ar_r",  0, 1, 1, KR, 2'b01, 3'd1, 8'd8); cyc();
    push("ar_a2", 0, 1, 1, KA, 2'b00, 3'd0, 8'd9); cyc();

    // Halt during a REG write to R2
    dR0 = 3'd2;
    r0 = KR;
    push("halt_wr", 0, 1, 1, KR, 2'b01, 3'd2, 8'd10); cyc();
    h0 = 1'b1;
    push("halt1", 0, 1, 0, K0, 2'b01, 3'd2, 8'd10); cyc();
    push("halt2", 0, 1, 0, K0, 2'b01, 3'd2, 8'd10); cyc();
    h0 = 1'b0;
    push("release", 0, 1, 0, K0, 2'b01, 3'd2, 8'd10); cyc();
    push("regrant", 0, 1, 1, KR, 2'b01, 3'd2, 8'd11); cyc();
    r0 = K0;
    push("post_hold", 0, 0, 0, K0, 2'b01, 3'd2, 8'd11); cyc();

    // Reset asserted mid-write
    dA0 = 3'd7;
    r0 = KA;
    push("pre_rst", 0, 1, 1, KA, 2'b00, 3'd7, 8'd12); cyc();
    #2 rst_n = 1'b0;
    #1;
    push("mid_rst", 0, 1, 0, K0, 2'b11, 3'd0, 8'd0);
    check();
    r0 = K0;
    #1 rst_n = 1'b1;
    push("after_rst", 0, 0, 0, K0, 2'b11, 3'd0, 8'd0); cyc();
    // Pointer back at A: A beats R
    r0 = KA | KR;
    push("ptr_rst", 0, 1, 1, KA, 2'b00, 3'd7, 8'd1); cyc();
    r0 = K0;

    // Fixed priority, 2-bit counter wraps
    dA1 = 3'd1; dZ1 = 3'd6; dR1 = 3'd3; dI1 = 3'd4;
    r1 = KA | KZ;
    push("fp_a1", 1, 1, 1, KA, 2'b00, 3'd1, 8'd1); cyc();
    push("fp_a2", 1, 1, 1, KA, 2'b00, 3'd1, 8'd2); cyc();
    push("fp_a3", 1, 1, 1, KA, 2'b00, 3'd1, 8'd3); cyc();
    r1 = KZ;
    push("fp_z",  1, 1, 1, KZ, 2'b11, 3'd6, 8'd0); cyc();
    r1 = KR | KI;
    push("fp_r",  1, 1, 1, KR, 2'b01, 3'd3, 8'd1); cyc();
    r1 = K0;
    push("fp_idle", 1, 0, 0, K0, 2'b01, 3'd3, 8'd1); cyc();

    total++;
    assert (sbq.size() == 0) else begin
      bad++;
      $error("FAIL sb_drain: left=%0d want=0", sbq.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
